fpadd_sched: RTL

Round-robin scheduler that shares one fpadd datapath instance between NREQ requesters.
- Accepts one operation at a time over per-requester valid/ready handshakes.
- Holds the operands stable on the fpadd inputs for LAT cycles, then captures result, flags and denorm.
- Returns the captured result to the consumer tagged with the requester index.
- Sits between the issue logic and the fpadd unit; no other block drives fpadd.

---
 rtl/fpadd_sched_if.sv | 40 ++++
 rtl/fpadd_sched.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/fpadd_sched_if.sv
// Request/response bundle of the fpadd round-robin scheduler.
// slave: scheduler side; master: issue/consumer side.
interface fpadd_sched_if #(
  parameter int NREQ = 4
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*64-1:0] req_op1;
  logic [NREQ*64-1:0] req_op2;
  logic [NREQ*3-1:0]  req_rm;
  logic [NREQ*3-1:0]  req_op_type;
  logic [NREQ*2-1:0]  req_p;

  logic               rsp_valid;
  logic               rsp_ready;
  logic [IW-1:0]      rsp_id;
  logic [63:0]        rsp_result;
  logic [4:0]         rsp_flags;
  logic               rsp_denorm;

  modport slave (
    input  req_valid, req_op1, req_op2,
    input  req_rm, req_op_type, req_p,
    input  rsp_ready,
    output req_ready,
    output rsp_valid, rsp_id, rsp_result,
    output rsp_flags, rsp_denorm
  );

  modport master (
    output req_valid, req_op1, req_op2,
    output req_rm, req_op_type, req_p,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid, rsp_id, rsp_result,
    input  rsp_flags, rsp_denorm
  );
endinterface

// File: rtl/fpadd_sched.sv
// Round-robin scheduler sharing one fpadd among NREQ requesters.
// Optional FPADD_SCHED_STATS_EN adds handshake/exception counters.
module fpadd_sched #(
  parameter int NREQ = 4,
  parameter int LAT  = 1
) (
  input  logic        clk,
  input  logic        reset,
  fpadd_sched_if.slave bus,
  input  logic        cfg_oven,
  input  logic        cfg_unen,
  output logic [63:0] fp_op1,
  output logic [63:0] fp_op2,
  output logic [2:0]  fp_rm,
  output logic [2:0]  fp_op_type,
  output logic [1:0]  fp_p,
  output logic        fp_oven,
  output logic        fp_unen,
  input  logic [63:0] fp_result,
  input  logic [4:0]  fp_flags,
  input  logic        fp_denorm
`ifdef FPADD_SCHED_STATS_EN
  ,
  output logic [31:0] stat_ops,
  output logic [31:0] stat_exc
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t        state_q;
  logic [IW-1:0] rr_q;
  logic [IW-1:0] rr_d;
  logic [CW-1:0] cnt_q;

  logic [63:0]   iss_op1_q;
  logic [63:0]   iss_op2_q;
  logic [2:0]    iss_rm_q;
  logic [2:0]    iss_ot_q;
  logic [1:0]    iss_p_q;
  logic [IW-1:0] iss_id_q;

  logic          rsp_vld_q;
  logic [IW-1:0] rsp_id_q;
  logic [63:0]   rsp_res_q;
  logic [4:0]    rsp_flg_q;
  logic          rsp_dn_q;

  logic [63:0]   op1_a [NREQ];
  logic [63:0]   op2_a [NREQ];
  logic [2:0]    rm_a  [NREQ];
  logic [2:0]    ot_a  [NREQ];
  logic [1:0]    p_a   [NREQ];
  logic [IW-1:0] cand  [NREQ];

  logic          gnt_ok;
  logic [IW-1:0] gnt_idx;
  logic [NREQ-1:0] rdy;

  for (genvar i = 0; i < NREQ; i++) begin : g_slot
    assign op1_a[i] = bus.req_op1[64*i +: 64];
    assign op2_a[i] = bus.req_op2[64*i +: 64];
    assign rm_a[i]  = bus.req_rm[3*i +: 3];
    assign ot_a[i]  = bus.req_op_type[3*i +: 3];
    assign p_a[i]   = bus.req_p[2*i +: 2];
  end

  function automatic logic [IW-1:0] wrap(input int a);
    return IW'((a >= NREQ) ? a - NREQ : a);
  endfunction

  // Search order starts at rr_q and wraps, so the pointer slot wins ties.
  always_comb begin
    gnt_ok  = 1'b0;
    gnt_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand[k] = wrap(int'(rr_q) + k);
    end
    for (int k = 0; k < NREQ; k++) begin
      if (!gnt_ok && bus.req_valid[cand[k]]) begin
        gnt_ok  = 1'b1;
        gnt_idx = cand[k];
      end
    end
  end

  assign rr_d = (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    rdy = '0;
    if (reset && state_q == IDLE && gnt_ok) begin
      rdy[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      rr_q      <= '0;
      cnt_q     <= '0;
      iss_op1_q <= '0;
      iss_op2_q <= '0;
      iss_rm_q  <= '0;
      iss_ot_q  <= '0;
      iss_p_q   <= '0;
      iss_id_q  <= '0;
      rsp_vld_q <= 1'b0;
      rsp_id_q  <= '0;
      rsp_res_q <= '0;
      rsp_flg_q <= '0;
      rsp_dn_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_ok) begin
            iss_op1_q <= op1_a[gnt_idx];
            iss_op2_q <= op2_a[gnt_idx];
            iss_rm_q  <= rm_a[gnt_idx];
            iss_ot_q  <= ot_a[gnt_idx];
            iss_p_q   <= p_a[gnt_idx];
            iss_id_q  <= gnt_idx;
            rr_q      <= rr_d;
            cnt_q     <= CW'(LAT);
            state_q   <= WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - 1'b1;
          // Sample exactly LAT edges after the issue load.
          if (cnt_q == CW'(1)) begin
            rsp_res_q <= fp_result;
            rsp_flg_q <= fp_flags;
            rsp_dn_q  <= fp_denorm;
            rsp_id_q  <= iss_id_q;
            rsp_vld_q <= 1'b1;
            state_q   <= RESP;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            rsp_vld_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.req_ready  = rdy;
  assign bus.rsp_valid  = rsp_vld_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_res_q;
  assign bus.rsp_flags  = rsp_flg_q;
  assign bus.rsp_denorm = rsp_dn_q;

  assign fp_op1     = iss_op1_q;
  assign fp_op2     = iss_op2_q;
  assign fp_rm      = iss_rm_q;
  assign fp_op_type = iss_ot_q;
  assign fp_p       = iss_p_q;
  assign fp_oven    = (state_q == WAIT) & cfg_oven;
  assign fp_unen    = (state_q == WAIT) & cfg_unen;

`ifdef FPADD_SCHED_STATS_EN
  logic [31:0] ops_q;
  logic [31:0] exc_q;
  logic        hs;

  assign hs = (state_q == RESP) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ops_q <= '0;
      exc_q <= '0;
    end else if (hs) begin
      if (ops_q != '1) ops_q <= ops_q + 1'b1;
      if (rsp_flg_q != '0 && exc_q != '1) begin
        exc_q <= exc_q + 1'b1;
      end
    end
  end

  assign stat_ops = ops_q;
  assign stat_exc = exc_q;
`endif

endmodule
